// File: rtl/arb_mux.sv
// N-channel registered multiplexer with valid/ready handshakes and internal
// round-robin or fixed-priority arbitration feeding a single output register.
module arb_mux #(
  parameter int WIDTH       = 32,
  parameter int NCH         = 4,
  parameter int SELW        = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SELW-1:0]      out_sel_q, out_sel_d;
  logic [SELW-1:0]      ptr_q, ptr_d;

  logic                 load_en_s;
  logic                 found_s;
  logic                 hit_s;
  logic [SELW-1:0]      grant_s;
  logic [SELW:0]        idx_raw_s;
  logic [SELW-1:0]      idx_s;
  logic [2**SELW-1:0]   valid_ext_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic [NCH-1:0]       in_ready_s;

  assign load_en_s = !out_valid_q || out_ready;

  // Rotating search starting at ptr; with ptr pinned at 0 this is lowest-index priority.
  always_comb begin
    found_s     = 1'b0;
    hit_s       = 1'b0;
    grant_s     = '0;
    idx_raw_s   = '0;
    idx_s       = '0;
    valid_ext_s = (2**SELW)'(in_valid);
    for (int i = 0; i < NCH; i++) begin
      idx_raw_s = {1'b0, ptr_q} + (SELW+1)'(i);
      idx_raw_s = (idx_raw_s >= (SELW+1)'(NCH)) ? (idx_raw_s - (SELW+1)'(NCH)) : idx_raw_s;
      idx_s     = idx_raw_s[SELW-1:0];
      hit_s     = !found_s && valid_ext_s[idx_s];
      grant_s   = hit_s ? idx_s : grant_s;
      found_s   = found_s | hit_s;
    end
  end

  // Granted channel's data word and the one-hot accept vector.
  always_comb begin
    sel_data_s = '0;
    in_ready_s = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_data_s    = (grant_s == SELW'(k)) ? in_data[k*WIDTH +: WIDTH] : sel_data_s;
      in_ready_s[k] = load_en_s && found_s && (grant_s == SELW'(k));
    end
  end

  // Output register and pointer next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en_s) begin
      out_valid_d = found_s;
      if (found_s) begin
        out_data_d = sel_data_s;
        out_sel_d  = grant_s;
        if (ROUND_ROBIN != 0) begin
          ptr_d = (grant_s == SELW'(NCH-1)) ? '0 : (grant_s + SELW'(1));
        end else begin
          ptr_d = '0;
        end
      end else begin
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance share stimulus
// and are compared each cycle against a modulo-arithmetic arbitration model.
module tb_arb_mux;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_ready;

  logic [NCH-1:0]   rdy_rr, rdy_fp;
  logic [WIDTH-1:0] dat_rr, dat_fp;
  logic [SELW-1:0]  sel_rr, sel_fp;
  logic             val_rr, val_fp;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_data(dat_rr), .out_sel(sel_rr),
    .out_valid(val_rr), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .out_data(dat_fp), .out_sel(sel_fp),
    .out_valid(val_fp), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model state per mode: index 0 = round robin, 1 = fixed priority.
  bit               m_valid [2];
  logic [WIDTH-1:0] m_data  [2];
  int               m_sel   [2];
  int               m_ptr   [2];
  bit               m_fresh [2];

  function automatic int pick(input int start, input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) begin
      if (v[(start + i) % NCH]) return (start + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] rnd_data();
    logic [NCH*WIDTH-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0; m_data[m] = '0; m_sel[m] = 0; m_ptr[m] = 0; m_fresh[m] = 1'b1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [NCH-1:0] v, input logic ordy,
                       input logic [NCH*WIDTH-1:0] d);
    bit             load [2];
    int             g    [2];
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    reset = rst; in_valid = v; out_ready = ordy; in_data = d;
    #1;
    for (int m = 0; m < 2; m++) begin
      load[m] = !m_valid[m] || ordy;
      g[m]    = pick(m_ptr[m], v);
      exp_rdy = (load[m] && g[m] >= 0) ? (NCH'(1) << g[m]) : '0;
      check($sformatf("m%0d in_ready", m), (m == 0) ? rdy_rr : rdy_fp, exp_rdy);
      check($sformatf("m%0d out_valid", m), (m == 0) ? val_rr : val_fp, m_valid[m]);
      if (m_valid[m] || m_fresh[m]) begin
        check($sformatf("m%0d out_data", m), (m == 0) ? dat_rr : dat_fp, m_data[m]);
        check($sformatf("m%0d out_sel", m), (m == 0) ? sel_rr : sel_fp, m_sel[m]);
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 1'b0; m_data[m] = '0; m_sel[m] = 0; m_ptr[m] = 0; m_fresh[m] = 1'b1;
      end else if (load[m]) begin
        if (g[m] >= 0) begin
          m_valid[m] = 1'b1;
          m_data[m]  = d[g[m]*WIDTH +: WIDTH];
          m_sel[m]   = g[m];
          m_fresh[m] = 1'b0;
          if (m == 0) m_ptr[m] = (g[m] + 1) % NCH;
        end else begin
          m_valid[m] = 1'b0;
        end
      end
    end
  endtask

  logic [NCH*WIDTH-1:0] d_fix;

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Idle after reset.
    repeat (5) cycle(1'b0, 4'b0000, 1'b1, rnd_data());

    // Single channel 2 transfer.
    d_fix = rnd_data();
    d_fix[2*WIDTH +: WIDTH] = 32'hA5A5_0002;
    cycle(1'b0, 4'b0100, 1'b1, d_fix);
    cycle(1'b0, 4'b0000, 1'b1, rnd_data());

    // All channels valid from ptr=0: rotation 0,1,2,3,0,1 without bubbles.
    cycle(1'b1, 4'b0000, 1'b1, rnd_data());
    repeat (7) cycle(1'b0, 4'b1111, 1'b1, rnd_data());

    // Backpressure hold with ch1/ch3 pending, then drain+load on one edge.
    d_fix = rnd_data();
    repeat (3) cycle(1'b0, 4'b1010, 1'b0, d_fix);
    cycle(1'b0, 4'b1010, 1'b1, d_fix);
    repeat (4) cycle(1'b0, 4'b1010, 1'b1, rnd_data());

    // Reset while holding with ptr=2, then first grant must be ch0.
    cycle(1'b1, 4'b0000, 1'b1, rnd_data());
    cycle(1'b0, 4'b0010, 1'b1, rnd_data());
    cycle(1'b0, 4'b0000, 1'b0, rnd_data());
    cycle(1'b1, 4'b0000, 1'b0, rnd_data());
    cycle(1'b0, 4'b1111, 1'b1, rnd_data());
    cycle(1'b0, 4'b0000, 1'b1, rnd_data());

    // Randomized traffic with occasional backpressure and resets.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            NCH'($urandom),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            rnd_data());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
